// File: rtl/dec_scan_seq_if.sv
// Bundle between the scan sequencer and whatever drives it (controller or bench).
// The master drives the sweep controls. The slave (the sequencer) drives the decoder select and enable lines.
interface dec_scan_seq_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [2:0] first_addr;
  logic [2:0] last_addr;
  logic       A0;
  logic       A1;
  logic       A2;
  logic       E1_n;
  logic       E2_n;
  logic       E3;
  logic       busy;
  logic       sweep_done;

  modport master (
    output start, stop, cont, first_addr, last_addr,
    input  A0, A1, A2, E1_n, E2_n, E3, busy, sweep_done
  );

  modport slave (
    input  start, stop, cont, first_addr, last_addr,
    output A0, A1, A2, E1_n, E2_n, E3, busy, sweep_done
  );
endinterface

// File: rtl/dec_scan_seq.sv
// Address-window scanner for a 3-to-8 active-low decoder.
// Each address is held for DWELL enabled cycles, with BLANK disabled cycles between addresses.
module dec_scan_seq #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  dec_scan_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANKING} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       addr_reg, addr_next;
  logic             cont_reg, cont_next;
  logic [2:0]       first_reg, first_next;
  logic [2:0]       last_reg, last_next;
  logic             done_next;
  logic             en_reg, en_n_reg, busy_reg, done_reg;
  logic [2:0]       step_addr;

  // Address to use for the next slot: wrap to the window start after the last address.
  assign step_addr = (addr_reg == last_reg) ? first_reg : addr_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    cont_next  = cont_reg;
    first_next = first_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        addr_next = 3'd0;
        if (bus.start) begin
          cont_next  = bus.cont;
          first_next = bus.first_addr;
          last_next  = bus.last_addr;
          addr_next  = bus.first_addr;
          cnt_next   = '0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.stop) begin
          state_next = IDLE;
          addr_next  = 3'd0;
          cnt_next   = '0;
        end else if (cnt_reg == DWELL_LAST) begin
          cnt_next = '0;
          if (addr_reg == last_reg && !cont_reg) begin
            state_next = IDLE;
            addr_next  = 3'd0;
            done_next  = 1'b1;
          end else if (BLANK > 0) begin
            state_next = BLANKING;
          end else begin
            addr_next = step_addr;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BLANKING: begin
        if (bus.stop) begin
          state_next = IDLE;
          addr_next  = 3'd0;
          cnt_next   = '0;
        end else if (cnt_reg == BLANK_LAST) begin
          // The address only moves on the edge that re-enables the decoder.
          state_next = ACTIVE;
          addr_next  = step_addr;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        addr_next  = 3'd0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= 3'd0;
      cont_reg  <= 1'b0;
      first_reg <= 3'd0;
      last_reg  <= 3'd0;
      en_reg    <= 1'b0;
      en_n_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      cont_reg  <= cont_next;
      first_reg <= first_next;
      last_reg  <= last_next;
      en_reg    <= (state_next == ACTIVE);
      en_n_reg  <= (state_next != ACTIVE);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= done_next;
    end
  end

  assign bus.A0         = addr_reg[0];
  assign bus.A1         = addr_reg[1];
  assign bus.A2         = addr_reg[2];
  assign bus.E3         = en_reg;
  assign bus.E1_n       = en_n_reg;
  assign bus.E2_n       = en_n_reg;
  assign bus.busy       = busy_reg;
  assign bus.sweep_done = done_reg;

endmodule
